// File: rtl/genius_sequence_player.sv
// Sequence player for the genius game: appends one LFSR colour per round and replays the
// stored sequence as timed on/off flashes; exposes a combinational read port for the checker.
module genius_sequence_player #(
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned ON_CYCLES  = 50000000,
  parameter int unsigned OFF_CYCLES = 25000000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       CLEAR,
  input  logic [1:0] C,
  output logic       END,
  output logic       LED_ON,
  output logic [1:0] COLOR,
  output logic [6:0] SEQ_LEN,
  output logic       FULL,
  output logic       BUSY,
  input  logic [5:0] RD_IDX,
  output logic [1:0] RD_COLOR
);

  localparam int unsigned AW      = $clog2(MAX_LEN);
  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {StIdle, StAppend, StOn, StOff, StDone} state_e;

  state_e          state_q, state_d;
  logic [6:0]      len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [TW-1:0]   t_on, t_off;
  logic            we;
  logic [1:0]      mem [MAX_LEN];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (we && !RESET) begin
      mem[len_q[AW-1:0]] <= lfsr_q[1:0];
    end
  end

  always_comb begin
    // Durations shrink with speed level but never reach zero.
    t_on  = TW'(ON_CYCLES >> C);
    t_off = TW'(OFF_CYCLES >> C);
    if (t_on == '0)  t_on  = TW'(1);
    if (t_off == '0) t_off = TW'(1);
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    we      = 1'b0;
    // Right-shift form of taps 16,14,13,11.
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    unique case (state_q)
      StIdle: begin
        if (START) state_d = StAppend;
      end
      StAppend: begin
        if (!FULL) begin
          we    = 1'b1;
          len_d = len_q + 7'd1;
        end
        idx_d   = '0;
        timer_d = t_on - TW'(1);
        state_d = StOn;
      end
      StOn: begin
        if (timer_q == '0) begin
          timer_d = t_off - TW'(1);
          state_d = StOff;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StOff: begin
        if (timer_q == '0) begin
          if (7'(idx_q) == len_q - 7'd1) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + AW'(1);
            timer_d = t_on - TW'(1);
            state_d = StOn;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // CLEAR wins over everything: empties the sequence and aborts any playback.
    if (CLEAR) begin
      state_d = StIdle;
      len_d   = '0;
      we      = 1'b0;
    end
  end

  assign END      = (state_q == StDone);
  assign LED_ON   = (state_q == StOn);
  assign COLOR    = (state_q == StOn) ? mem[idx_q] : 2'd0;
  assign BUSY     = (state_q != StIdle);
  assign SEQ_LEN  = len_q;
  assign FULL     = (len_q == 7'(MAX_LEN));
  assign RD_COLOR = ({1'b0, RD_IDX} < len_q) ? mem[RD_IDX[AW-1:0]] : 2'd0;

endmodule

// File: tb/tb_genius_sequence_player.sv
// Randomized self-checking bench for genius_sequence_player against a queue-based
// reference model of the stored sequence and the flash timeline.
module tb_genius_sequence_player;

  localparam int unsigned MaxLen = 4;
  localparam int unsigned OnCyc  = 4;
  localparam int unsigned OffCyc = 2;
  localparam logic [15:0] Seed   = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] c = 2'd0;
  logic       end_pulse, led_on, full, busy;
  logic [1:0] color, rd_color;
  logic [6:0] seq_len;
  logic [5:0] rd_idx = 6'd0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_seq[$];
  logic [15:0] ref_lfsr;
  logic [1:0]  s1_color;

  genius_sequence_player #(
    .MAX_LEN   (MaxLen),
    .ON_CYCLES (OnCyc),
    .OFF_CYCLES(OffCyc),
    .LFSR_SEED (Seed)
  ) dut (
    .CLK     (clk),
    .RESET   (reset),
    .START   (start),
    .CLEAR   (clear),
    .C       (c),
    .END     (end_pulse),
    .LED_ON  (led_on),
    .COLOR   (color),
    .SEQ_LEN (seq_len),
    .FULL    (full),
    .BUSY    (busy),
    .RD_IDX  (rd_idx),
    .RD_COLOR(rd_color)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] b;
    b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'd1;
    return (x >> 1) | (b << 15);
  endfunction

  // Free-running reference LFSR: the colour of an append is its value during APPEND.
  always @(posedge clk) begin
    if (reset) ref_lfsr <= Seed;
    else       ref_lfsr <= lfsr_step(ref_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_at(input int i);
    if (i < exp_seq.size()) return int'(exp_seq[i]);
    return 0;
  endfunction

  task automatic check_mem();
    for (int i = 0; i <= MaxLen + 1; i++) begin
      rd_idx = 6'(i);
      #1;
      check("rd_color", rd_color, exp_at(i));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = $urandom_range(0, 7);
      rd_idx = 6'(k);
      #1;
      check("idle_busy", busy, 0);
      check("idle_end", end_pulse, 0);
      check("idle_led", led_on, 0);
      check("idle_rd", rd_color, exp_at(k));
      tick();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    exp_seq.delete();
    check("rst_busy", busy, 0);
    check("rst_led", led_on, 0);
    check("rst_color", color, 0);
    check("rst_end", end_pulse, 0);
    check("rst_len", seq_len, 0);
    check("rst_full", full, 0);
    reset = 1'b0;
  endtask

  task automatic clear_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_seq.delete();
    check("clr_idle_len", seq_len, 0);
    check("clr_idle_busy", busy, 0);
  endtask

  // mode 0 plain, 1 START during ON, 2 CLEAR in first OFF, 3 RESET mid-ON
  task automatic play_round(input int cl, input int mode);
    int ton, toff, per, len, total, r, want_col;
    logic led;
    logic [1:0] col;
    c = 2'(cl);
    ton  = OnCyc >> cl;
    toff = OffCyc >> cl;
    if (ton == 0) ton = 1;
    if (toff == 0) toff = 1;
    per = ton + toff;
    start = 1'b1;
    tick();
    start = 1'b0;
    col = ref_lfsr[1:0];
    if (exp_seq.size() < MaxLen) exp_seq.push_back(col);
    len = exp_seq.size();
    total = 2 + len * per;
    for (int o = 1; o <= total + 1; o++) begin
      r = o - 2;
      led = (o >= 2) && (o < total) && ((r % per) < ton);
      want_col = led ? int'(exp_seq[r / per]) : 0;
      check("busy", busy, 32'(o <= total));
      check("end", end_pulse, 32'(o == total));
      check("led_on", led_on, 32'(led));
      check("color", color, want_col);
      if (mode == 2 && o == 2 + ton) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_seq.delete();
        check("abort_busy", busy, 0);
        check("abort_len", seq_len, 0);
        check("abort_led", led_on, 0);
        check("abort_color", color, 0);
        idle(4);
        return;
      end
      if (mode == 3 && o == 3) begin
        apply_reset();
        return;
      end
      start = (mode == 1 && o == 3);
      tick();
    end
    start = 1'b0;
    check("seq_len", seq_len, len);
    check("full", full, 32'(len == MaxLen));
  endtask

  initial begin
    tick();
    // Scenario 1: single step after reset
    apply_reset();
    idle(3);
    play_round(0, 0);
    s1_color = exp_seq[0];
    check_mem();
    // Scenario 2: fill to MAX_LEN
    for (int i = 0; i < 3; i++) begin
      idle(2);
      play_round(0, 0);
      check_mem();
    end
    // Scenario 3: START while full replays without appending
    idle(1);
    play_round(0, 0);
    check_mem();
    // Scenario 4: fastest speed, clamped durations
    clear_idle();
    play_round(2, 0);
    play_round(2, 0);
    check_mem();
    // Scenario 5: START during ON, CLEAR during OFF, START+CLEAR in IDLE
    idle(1);
    play_round(0, 1);
    idle(2);
    idle(1);
    play_round(0, 2);
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    exp_seq.delete();
    check("sc_busy", busy, 0);
    check("sc_len", seq_len, 0);
    tick();
    check("sc_busy2", busy, 0);
    // Scenario 6: reset mid-ON, then same offset gives same colour
    idle(2);
    play_round(0, 3);
    idle(3);
    play_round(0, 0);
    rd_idx = 6'd0;
    #1;
    check("s6_repeat", rd_color, s1_color);
    // Randomized rounds
    for (int i = 0; i < 14; i++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) clear_idle();
      play_round($urandom_range(0, 3), $urandom_range(0, 1));
      check_mem();
    end
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/genius_sequence_player.md
Name: genius_sequence_player

Overview:
- Downstream of the genius controller. Consumes its START_1 pulse and returns the END_1 pulse.
- Each round: appends one pseudo-random colour to the stored game sequence, then plays the whole sequence as timed on/off colour flashes for the LED/VGA layer.
- Exposes a combinational read port so the player-input checker (the START_2/END_2 stage) can compare button presses against the stored sequence.

Parameters:
- MAX_LEN, 32, sequence storage depth (power of 2, at most 64).
- ON_CYCLES, 50000000, flash-on duration at speed level 0.
- OFF_CYCLES, 25000000, gap duration at speed level 0.
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request from controller (START_1): append a step and play.
- CLEAR  in  1  new game: empty the sequence.
- C  in  2  speed level from controller; 0 is slowest.
- END  out  1  one-cycle pulse when playback completes (to END_1).
- LED_ON  out  1  high while a colour flash is displayed.
- COLOR  out  2  colour being flashed: 0 green, 1 red, 2 blue, 3 yellow. 0 when LED_ON is low.
- SEQ_LEN  out  7  number of stored steps.
- FULL  out  1  SEQ_LEN == MAX_LEN.
- BUSY  out  1  state is not IDLE.
- RD_IDX  in  6  checker read index.
- RD_COLOR  out  2  mem[RD_IDX] (combinational). 0 if RD_IDX >= SEQ_LEN.

Behaviour:
- Reset (synchronous, RESET high at a CLK edge):
  - state=IDLE, SEQ_LEN=0, play index=0, timer=0, LFSR=LFSR_SEED.
  - END=0, LED_ON=0, COLOR=0, BUSY=0, FULL=0.
  - Memory contents don't-care.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle including while busy.
  - New colour = LFSR[1:0] sampled at the APPEND edge.
- Durations:
  - T_on = ON_CYCLES >> C, T_off = OFF_CYCLES >> C, each clamped to a minimum of 1.
  - C is sampled on entry to each ON or OFF state.
- States: IDLE, APPEND, ON, OFF, DONE.
- IDLE:
  - START=1 -> APPEND.
  - CLEAR=1 -> SEQ_LEN=0, stay in IDLE.
  - CLEAR has priority over START in the same cycle; START is then dropped.
- APPEND:
  - If not FULL: mem[SEQ_LEN] = LFSR[1:0], SEQ_LEN += 1.
  - If FULL: no write.
  - Play index = 0, load timer, -> ON.
- ON:
  - LED_ON=1, COLOR=mem[index].
  - Timer counts T_on cycles, then load timer -> OFF.
- OFF:
  - LED_ON=0, COLOR=0, for T_off cycles.
  - Then: if index == SEQ_LEN-1 -> DONE; else index += 1 -> ON.
- DONE: END=1 for exactly one cycle -> IDLE.
- Outputs:
  - END, LED_ON and COLOR are decoded from registered state only (glitch-free, no input-to-output path).
  - RD_COLOR is the only combinational output.
- Latency: START high at edge k gives APPEND during cycle k+1 and the first LED_ON during cycle k+2.
- Total busy cycles from the START edge to END = 1 + SEQ_LEN*(T_on+T_off) + 1, where SEQ_LEN is the post-append value.
- START while BUSY: ignored, not queued.
- CLEAR while BUSY: aborts to IDLE next edge, SEQ_LEN=0, LED_ON/COLOR=0, no END pulse.
- Full sequence: START still plays all MAX_LEN steps and END fires. FULL tells the controller to signal a win.
- RESET mid-playback: immediate return to the reset values above, no END.

Test Plan:
Bench parameters: ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=4, C=0.

1. Reset, then one START pulse -> SEQ_LEN=1. LED_ON high for 4 cycles starting at k+2, then low for 2. END pulses at k+8. COLOR equals the LFSR[1:0] captured at APPEND. RD_IDX=0 returns the same value.
2. Three more START pulses, each after the prior END -> SEQ_LEN=4, FULL=1. The 4th playback shows 4 flashes whose colours match RD_COLOR[0..3]. Earlier steps are unchanged across rounds.
3. FULL, then START -> no append, SEQ_LEN stays 4, 4 flashes play, END fires after 1+24+1 cycles.
4. C=2 -> T_on=1, T_off=1 (clamped). With SEQ_LEN=2, END arrives 6 cycles after the START edge.
5. START during ON -> ignored: SEQ_LEN unchanged, exactly one END. CLEAR during OFF -> IDLE next cycle, SEQ_LEN=0, no END. START and CLEAR together in IDLE -> SEQ_LEN=0, stays IDLE.
6. RESET asserted mid-ON -> next edge: LED_ON=0, COLOR=0, BUSY=0, SEQ_LEN=0. The colour sequence after a re-START repeats the colours of scenario 1 (same seed, same cycle offset).
